dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the memory-access interface. It sits at the far end of the bus that the LC-3 MemAccess stage drives, and acts as the data memory. It accepts a single read or write request on MControl/MAddr/MData. After a programmable number of wait states it performs the access, returns read data on DMem_out and pulses completedata for one cycle. It is a synthesizable model used both in the integrated design and as the DUT-side counterpart of the memaccess_out agent.

## Interface
- ADDR_BITS, 8: implemented word-address bits; depth = 2^ADDR_BITS 16-bit words (legal 1..12).
- WAIT_STATES, 2: wait cycles inserted between request acceptance and the access (legal 0..15).
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted = 0.
- mem_req  input  1  request strobe; sampled only in IDLE.
- MControl  input  1  access type: 0 = read, 1 = write.
- MAddr  input  16  word address.
- MData  input  16  write data.
- DMem_out  output  16  registered read data.
- completedata  output  1  one-cycle completion pulse.
- busy  output  1  high whenever the state is not IDLE.
- addr_err  output  1  one-cycle pulse, coincident with completedata, for an out-of-range address.

## Operation
- States: IDLE, WAIT, RESP. busy = (state != IDLE).
- IDLE:
  - mem_req=1 at an edge → capture MControl, MAddr and MData into request registers.
  - Load the 4-bit wait counter with WAIT_STATES and go to WAIT.
  - mem_req=0 → stay in IDLE.
- WAIT:
  - Counter ≠ 0 → decrement and stay in WAIT.
  - Counter = 0 → perform the access on this edge, go to RESP, set completedata=1.
- Access, performed at the WAIT→RESP edge using only the captured values:
  - In range (MAddr[15:ADDR_BITS] all zero), read: DMem_out ← mem[MAddr[ADDR_BITS-1:0]].
  - In range, write: mem[...] ← MData; DMem_out unchanged.
  - Out of range: no array write; a read loads DMem_out ← 16'h0000; addr_err=1.
- RESP: completedata and addr_err clear at the next edge, state → IDLE, unconditionally.
- mem_req in WAIT or RESP is ignored; it is not queued.
- Input changes after acceptance do not affect the access in flight.
- DMem_out holds the last read value until the next read completes.
- The memory array has no reset and powers up undefined. Reads of never-written words return X in simulation. Benches write before reading.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, counter=0, DMem_out=16'h0000, completedata=0, addr_err=0, busy=0.
  - The request registers clear. The memory array is untouched.
- Reset mid-operation aborts the request. A pending write is not committed. No completedata is produced.
- Release is synchronous in effect: the first mem_req is sampled at the first rising edge with reset=1.
- Latency:
  - Accept at edge E0; access and completedata rise at edge E(WAIT_STATES+1); completedata falls at E(WAIT_STATES+2).
  - WAIT_STATES=0 gives completion one edge after acceptance.
- Throughput: the next request is accepted no earlier than E(WAIT_STATES+3), so the period is WAIT_STATES+3 cycles.
- busy rises at E0 and falls at E(WAIT_STATES+2).
- Read-after-write to the same address in consecutive requests returns the new data.
- Counter width of 4 bits supports WAIT_STATES up to 15. The counter never underflows: the decrement is gated by counter ≠ 0.

## Test plan
- Reset values: hold reset=0 with random inputs → DMem_out=0000, completedata=0, busy=0, addr_err=0. Release it; mem_req=0 for 10 cycles → no output change.
- Write then read, WAIT_STATES=2:
  - Write MAddr=0x0012, MData=0xBEEF → completedata high exactly at E3 for one cycle; DMem_out stays 0000.
  - Then read 0x0012 → DMem_out=0xBEEF at that request's E3.
- Zero wait states: WAIT_STATES=0, write 0x00FF=0x1234 then read it → completedata one edge after each accept; DMem_out=0x1234.
- Busy drop:
  - Hold mem_req=1 continuously with read 0x0001 → accepts only at E0, E5, E10 (WAIT_STATES=2).
  - Change MAddr during WAIT → the returned data is from the captured address.
- Out of range, ADDR_BITS=8:
  - Write 0x0100=0xAAAA → addr_err and completedata pulse together; mem[0x00] is unchanged.
  - Read 0x0100 → DMem_out=0x0000 with addr_err.
- Reset mid-operation:
  - Write 0x0005=0x5555 and assert reset in WAIT → no completedata; busy drops immediately.
  - After release, read 0x0005 → the previously written value, not 0x5555.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one read/write request, waits WAIT_STATES cycles,
// performs the access and pulses completedata (plus addr_err for out-of-range addresses).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for mem_req; request registers loaded on accept
// ST_WAIT | counting down wait states; access happens when counter is 0
// ST_RESP | completedata/addr_err high for this cycle; back to idle next
module dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        MControl,
    input  logic [15:0] MAddr,
    input  logic [15:0] MData,
    output logic [15:0] DMem_out,
    output logic        completedata,
    output logic        busy,
    output logic        addr_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_ctl;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        w_access;
    logic        w_in_range;
    logic [15:0] r_mem [DEPTH];

    assign w_in_range = (r_addr[15:ADDR_BITS] == '0);
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 4'd0;
            r_ctl        <= 1'b0;
            r_addr       <= 16'h0000;
            r_data       <= 16'h0000;
            DMem_out     <= 16'h0000;
            completedata <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && mem_req) begin
                r_ctl  <= MControl;
                r_addr <= MAddr;
                r_data <= MData;
                r_cnt  <= 4'(WAIT_STATES);
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            completedata <= w_access;
            addr_err     <= w_access && !w_in_range;
            // Out-of-range reads return zero rather than aliasing into the array.
            if (w_access && !r_ctl) begin
                DMem_out <= w_in_range ? r_mem[r_addr[ADDR_BITS-1:0]] : 16'h0000;
            end
        end
    end

    // Array carries no reset; an aborted request never reaches ST_WAIT's access edge.
    always_ff @(posedge clock) begin
        if (w_access && r_ctl && w_in_range) begin
            r_mem[r_addr[ADDR_BITS-1:0]] <= r_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a behavioural memory model. Instance 0 has 2 wait states, instance 1 has 0.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req [2];
    logic        mctl    [2];
    logic [15:0] maddr   [2];
    logic [15:0] mdata   [2];
    logic [15:0] dmo     [2];
    logic        cd      [2];
    logic        bsy     [2];
    logic        ae      [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(2)) u_dut_ws2 (
        .clock(clock), .reset(reset), .mem_req(mem_req[0]), .MControl(mctl[0]),
        .MAddr(maddr[0]), .MData(mdata[0]), .DMem_out(dmo[0]),
        .completedata(cd[0]), .busy(bsy[0]), .addr_err(ae[0])
    );

    dmem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_dut_ws0 (
        .clock(clock), .reset(reset), .mem_req(mem_req[1]), .MControl(mctl[1]),
        .MAddr(maddr[1]), .MData(mdata[1]), .DMem_out(dmo[1]),
        .completedata(cd[1]), .busy(bsy[1]), .addr_err(ae[1])
    );

    // Issue one request on instance k; after acceptance the inputs are changed to
    // a_after/random values so that only the captured request can matter.
    task automatic do_req(input int k, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] a_after,
                          output int lat, output logic [15:0] dout,
                          output logic aerr, output logic cd_after,
                          output logic busy_after);
        @(negedge clock);
        mem_req[k] = 1'b1;
        mctl[k]    = wr;
        maddr[k]   = a;
        mdata[k]   = d;
        @(posedge clock);
        #1;
        mem_req[k] = 1'b0;
        mctl[k]    = 1'($urandom);
        maddr[k]   = a_after;
        mdata[k]   = 16'($urandom);
        lat  = -1;
        dout = 'x;
        aerr = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1;
            if (cd[k]) begin
                lat  = i;
                dout = dmo[k];
                aerr = ae[k];
                break;
            end
        end
        @(posedge clock);
        #1;
        cd_after   = cd[k];
        busy_after = bsy[k];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                mem_req[k] = 1'($urandom);
                mctl[k]    = 1'($urandom);
                maddr[k]   = 16'($urandom);
                mdata[k]   = 16'($urandom);
            end
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({dmo[k], cd[k], bsy[k], ae[k]} !== 19'h0) begin
                    n_err++;
                    $display("FAIL reset_hold dut%0d: dout=%h cd=%b busy=%b aerr=%b, want 0000/0/0/0",
                             k, dmo[k], cd[k], bsy[k], ae[k]);
                end
            end
        end
        @(negedge clock);
        mem_req[0] = 1'b0;
        mem_req[1] = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({dmo[k], cd[k], bsy[k], ae[k]} !== 19'h0) begin
                    n_err++;
                    $display("FAIL reset_idle dut%0d cyc%0d: dout=%h cd=%b busy=%b aerr=%b, want 0000/0/0/0",
                             k, c, dmo[k], cd[k], bsy[k], ae[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] dout; logic aerr, cda, bya;
        do_req(0, 1'b1, 16'h0012, 16'hBEEF, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'h0000 || aerr !== 1'b0) begin
            n_err++;
            $display("FAIL wr_0012: lat=%0d dout=%h aerr=%b, want 3/0000/0", lat, dout, aerr);
        end
        n_checks++;
        if (cda !== 1'b0 || bya !== 1'b0) begin
            n_err++;
            $display("FAIL wr_pulse_end: cd=%b busy=%b, want 0/0", cda, bya);
        end
        do_req(0, 1'b0, 16'h0012, 16'($urandom), 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'hBEEF || aerr !== 1'b0) begin
            n_err++;
            $display("FAIL rd_0012: lat=%0d dout=%h aerr=%b, want 3/beef/0", lat, dout, aerr);
        end
        n_checks++;
        if (cda !== 1'b0 || dmo[0] !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_hold: cd=%b dout=%h, want 0/beef", cda, dmo[0]);
        end
    endtask

    task automatic test_zero_wait();
        int lat; logic [15:0] dout; logic aerr, cda, bya;
        do_req(1, 1'b1, 16'h00FF, 16'h1234, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 1 || dout !== 16'h0000 || cda !== 1'b0) begin
            n_err++;
            $display("FAIL zw_write: lat=%0d dout=%h cd_after=%b, want 1/0000/0", lat, dout, cda);
        end
        do_req(1, 1'b0, 16'h00FF, 16'h0000, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 1 || dout !== 16'h1234 || bya !== 1'b0) begin
            n_err++;
            $display("FAIL zw_read: lat=%0d dout=%h busy_after=%b, want 1/1234/0", lat, dout, bya);
        end
    endtask

    task automatic test_busy_drop();
        int lat; logic [15:0] dout; logic aerr, cda, bya, prev;
        int acc[$];
        int cds[$];
        do_req(0, 1'b1, 16'h0001, 16'h1111, 16'($urandom), lat, dout, aerr, cda, bya);
        do_req(0, 1'b1, 16'h0002, 16'h2222, 16'($urandom), lat, dout, aerr, cda, bya);
        do_req(0, 1'b0, 16'h0001, 16'h0000, 16'h0002, lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'h1111) begin
            n_err++;
            $display("FAIL addr_capture: lat=%0d dout=%h, want 3/1111", lat, dout);
        end
        @(negedge clock);
        mem_req[0] = 1'b1;
        mctl[0]    = 1'b0;
        maddr[0]   = 16'h0001;
        for (int e = 0; e < 12; e++) begin
            prev = bsy[0];
            @(posedge clock);
            #1;
            if (!prev && bsy[0]) acc.push_back(e);
            if (cd[0]) cds.push_back(e);
        end
        @(negedge clock);
        mem_req[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if (acc.size() != 3 || acc[0] != 0 || acc[1] != 5 || acc[2] != 10) begin
            n_err++;
            $display("FAIL hold_accepts: got %0d accepts %p, want edges 0,5,10", acc.size(), acc);
        end
        n_checks++;
        if (cds.size() != 2 || cds[0] != 3 || cds[1] != 8) begin
            n_err++;
            $display("FAIL hold_completions: got %p, want edges 3,8", cds);
        end
        n_checks++;
        if (dmo[0] !== 16'h1111 || bsy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hold_end: dout=%h busy=%b, want 1111/0", dmo[0], bsy[0]);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] dout; logic aerr, cda, bya;
        do_req(0, 1'b1, 16'h0000, 16'h0F0F, 16'($urandom), lat, dout, aerr, cda, bya);
        do_req(0, 1'b1, 16'h0100, 16'hAAAA, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || aerr !== 1'b1) begin
            n_err++;
            $display("FAIL oor_write: lat=%0d aerr=%b, want 3/1", lat, aerr);
        end
        n_checks++;
        if (ae[0] !== 1'b0 || cda !== 1'b0) begin
            n_err++;
            $display("FAIL oor_pulse_end: aerr=%b cd=%b, want 0/0", ae[0], cda);
        end
        do_req(0, 1'b0, 16'h0000, 16'h0000, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'h0F0F || aerr !== 1'b0) begin
            n_err++;
            $display("FAIL oor_no_alias: lat=%0d dout=%h aerr=%b, want 3/0f0f/0", lat, dout, aerr);
        end
        do_req(0, 1'b0, 16'h0100, 16'h0000, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'h0000 || aerr !== 1'b1) begin
            n_err++;
            $display("FAIL oor_read: lat=%0d dout=%h aerr=%b, want 3/0000/1", lat, dout, aerr);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] dout; logic aerr, cda, bya;
        int seen_cd;
        do_req(0, 1'b1, 16'h0005, 16'h7777, 16'($urandom), lat, dout, aerr, cda, bya);
        @(negedge clock);
        mem_req[0] = 1'b1;
        mctl[0]    = 1'b1;
        maddr[0]   = 16'h0005;
        mdata[0]   = 16'h5555;
        @(posedge clock);
        #1;
        mem_req[0] = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bsy[0] !== 1'b0 || cd[0] !== 1'b0 || dmo[0] !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset_async: busy=%b cd=%b dout=%h, want 0/0/0000", bsy[0], cd[0], dmo[0]);
        end
        seen_cd = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (cd[0]) seen_cd++;
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (cd[0] || bsy[0]) seen_cd++;
        end
        n_checks++;
        if (seen_cd != 0) begin
            n_err++;
            $display("FAIL mid_reset_no_cd: %0d cycles with cd/busy, want 0", seen_cd);
        end
        do_req(0, 1'b0, 16'h0005, 16'h0000, 16'($urandom), lat, dout, aerr, cda, bya);
        n_checks++;
        if (lat !== 3 || dout !== 16'h7777) begin
            n_err++;
            $display("FAIL mid_reset_not_committed: lat=%0d dout=%h, want 3/7777", lat, dout);
        end
    endtask

    // Random traffic over a fresh region 0x80..0x8F plus occasional out-of-range
    // addresses, compared with an array model of the memory and the read register.
    task automatic test_random();
        int lat; logic [15:0] dout; logic aerr, cda, bya;
        logic [15:0] mdl [256];
        bit          vld [256];
        logic [15:0] mdl_dout;
        logic [15:0] a, d;
        logic        wr;
        bit          oor;
        for (int i = 0; i < 256; i++) vld[i] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        mdl_dout = 16'h0000;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            oor = ($urandom_range(0, 9) == 0);
            a = oor ? 16'($urandom_range(256, 65535)) : 16'h0080 + 16'($urandom_range(0, 15));
            wr = 1'($urandom);
            if (!oor && !wr && !vld[a[7:0]]) wr = 1'b1;
            d = 16'($urandom);
            do_req(0, wr, a, d, 16'($urandom), lat, dout, aerr, cda, bya);
            if (wr) begin
                if (!oor) begin
                    mdl[a[7:0]] = d;
                    vld[a[7:0]] = 1'b1;
                end
            end else begin
                mdl_dout = oor ? 16'h0000 : mdl[a[7:0]];
            end
            n_checks++;
            if (lat !== 3 || dout !== mdl_dout || aerr !== oor || cda !== 1'b0) begin
                n_err++;
                $display("FAIL rand#%0d %s a=%h: lat=%0d dout=%h aerr=%b cd_after=%b, want 3/%h/%b/0",
                         n, wr ? "wr" : "rd", a, lat, dout, aerr, cda, mdl_dout, oor);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_req[k] = 1'b0;
            mctl[k]    = 1'b0;
            maddr[k]   = 16'h0000;
            mdata[k]   = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_zero_wait();
        test_busy_drop();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
